// File: rtl/piece_scheduler.sv
// piece_scheduler: 7-bag tetromino sequencer.
// It draws pieces from an LFSR word by rejection sampling. After max_reject_p
// tries it falls back to the lowest unused piece. Drawn pieces go into a
// shallow preview FIFO that is consumed through a valid/yumi handshake.
module piece_scheduler #(
    parameter int rand_width_p  = 16,
    parameter int queue_depth_p = 3,
    parameter int max_reject_p  = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [rand_width_p-1:0]    random_i,
    output logic [2:0]                 piece_o,
    output logic                       piece_v_o,
    input  logic                       piece_yumi_i,
    output logic [3*queue_depth_p-1:0] preview_o,
    output logic [2:0]                 count_o,
    output logic [6:0]                 bag_o
);

    localparam int RCW = (max_reject_p > 1) ? $clog2(max_reject_p) : 1;
    localparam logic [2:0]     DEPTH   = 3'(queue_depth_p);
    localparam logic [RCW-1:0] REJ_MAX = RCW'(max_reject_p - 1);

    typedef enum logic {DRAW = 1'b0, HOLD = 1'b1} state_e;

    state_e                          state_q, state_n;
    logic [queue_depth_p-1:0][2:0]   fifo_q, fifo_n;
    logic [2:0]                      count_q, count_n;
    logic [6:0]                      bag_q, bag_n, bag_clr;
    logic [RCW-1:0]                  rej_q, rej_n;

    logic [2:0] cand, low_pick, pick, wr_idx;
    logic [7:0] bag_x;
    logic       pop, draw_en, accept, fallback, push;

    // Only the low three bits of the LFSR word carry a candidate.
    generate
        if (rand_width_p > 3) begin : g_unused_rand
            logic unused_rand_bits;
            assign unused_rand_bits = ^random_i[rand_width_p-1:3];
        end
    endgenerate

    assign cand  = random_i[2:0];
    assign bag_x = {1'b0, bag_q};     // candidate 7 lands on the zero pad

    // Handshake, draw decision and the fallback pick.
    always_comb begin
        pop      = piece_yumi_i && (count_q != 3'd0);
        // A full FIFO can still take a piece when the head leaves on the same edge.
        draw_en  = ((state_q == DRAW) && (count_q < DEPTH)) || pop;
        accept   = bag_x[cand];
        fallback = !accept && (rej_q == REJ_MAX);
        push     = draw_en && (accept || fallback);
        low_pick = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (bag_q[i]) low_pick = 3'(i);
        end
        pick = accept ? cand : low_pick;
    end

    // Next bag, reject counter and FIFO contents.
    always_comb begin
        bag_clr = bag_q & ~(7'b1 << pick);
        bag_n   = bag_q;
        if (push) bag_n = (bag_clr == 7'd0) ? 7'h7F : bag_clr;

        rej_n = rej_q;
        if (draw_en) rej_n = push ? '0 : rej_q + 1'b1;

        fifo_n = fifo_q;
        if (pop) begin
            for (int i = 0; i < queue_depth_p - 1; i++) fifo_n[i] = fifo_q[i+1];
            fifo_n[queue_depth_p-1] = 3'd0;
        end
        // Slot indexes shift down by one when a pop happens on the same edge.
        wr_idx = count_q - {2'b0, pop};
        for (int i = 0; i < queue_depth_p; i++) begin
            if (push && (wr_idx == 3'(i))) fifo_n[i] = pick;
        end
        count_n = count_q + {2'b0, push} - {2'b0, pop};
    end

    // DRAW/HOLD next state: park when full with nobody consuming.
    always_comb begin
        state_n = state_q;
        case (state_q)
            DRAW: if (push && !pop && (count_n == DEPTH)) state_n = HOLD;
            HOLD: if (pop) state_n = DRAW;
            default: state_n = DRAW;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= DRAW;
            fifo_q  <= '0;
            count_q <= 3'd0;
            bag_q   <= 7'h7F;
            rej_q   <= '0;
        end else begin
            state_q <= state_n;
            fifo_q  <= fifo_n;
            count_q <= count_n;
            bag_q   <= bag_n;
            rej_q   <= rej_n;
        end
    end

    assign piece_o   = fifo_q[0];
    assign piece_v_o = (count_q != 3'd0);
    assign preview_o = fifo_q;
    assign count_o   = count_q;
    assign bag_o     = bag_q;

endmodule

// File: doc/piece_scheduler.md
# piece_scheduler

Tetromino sequencer that turns the free-running LFSR word from `random_generator` into a 7-bag piece stream. It holds a bag mask, draws unused pieces by rejection sampling with a bounded-latency fallback, and buffers drawn pieces in a small preview FIFO. The game control FSM consumes the head piece through a valid/yumi handshake, and the preview entries drive the "next" display.

## Interface
- `rand_width_p`, default 16: width of the random word input; must be ≥ 3.
- `queue_depth_p`, default 3: preview FIFO depth; legal range 1..7.
- `max_reject_p`, default 8: consecutive rejected draws before the fallback pick.
- `clk_i`, input, 1: the single clock.
- `reset_n_i`, input, 1: reset, synchronous and active-low.
- `random_i`, input, `rand_width_p`: LFSR word; the block uses bits [2:0] only and treats them as changing every cycle.
- `piece_o`, output, 3: head piece, encoded 0..6 = I, O, T, S, Z, J, L.
- `piece_v_o`, output, 1: `piece_o` is valid; high whenever the FIFO is non-empty.
- `piece_yumi_i`, input, 1: consume the head piece. Legal only while `piece_v_o` is high; ignored otherwise.
- `preview_o`, output, 3*`queue_depth_p`: FIFO contents, entry k at bits [3k+2:3k]. Entry 0 is the head. Entries at index ≥ `count_o` read 0.
- `count_o`, output, 3: number of FIFO entries.
- `bag_o`, output, 7: pieces still available in the current bag; bit i set means piece i is unused.

## Operation
- Draw enable: `count_o` < `queue_depth_p`, or the FIFO is full and `piece_yumi_i` is high. At most one draw per cycle.
- Candidate `c = random_i[2:0]`:
  - Accepted when `c` ≠ 7 and `bag_o[c]` = 1.
  - Otherwise rejected, and the reject counter increments.
- Fallback: if the reject counter equals `max_reject_p`-1 and the current candidate is rejected, the block picks the lowest-index set bit of `bag_o`. This pick always succeeds, so any draw completes in at most `max_reject_p` cycles.
- On any accepted or fallback draw:
  - clear that bit in the bag;
  - push the piece at the FIFO tail;
  - reset the reject counter to 0.
- Bag refill: if a draw clears the last set bit, `bag_o` loads 7'h7F on the same edge. The next draw starts a fresh bag, so `bag_o` is never observed as 0.
- Reject counter holds its value while the draw is disabled.
- FIFO: push and pop in the same cycle are legal at any count; `count_o` is then unchanged and the order is preserved. A pop shifts the preview entries toward the head.
- State machine:
  - DRAW (draw enabled) ↔ HOLD (FIFO full, no yumi).
  - HOLD→DRAW on yumi. DRAW→HOLD when a push makes `count_o` = `queue_depth_p` with no pop.
  - Reset state: DRAW.

## Timing
- Reset (`reset_n_i` low at an edge) forces:
  - `count_o` = 0, `piece_v_o` = 0, `piece_o` = 0, `preview_o` = 0;
  - `bag_o` = 7'h7F, reject counter = 0, state DRAW.
- Reset mid-operation discards the FIFO contents and the partial bag.
- Latency: a draw accepted in cycle n appears in `preview_o`/`count_o` after edge n. It is on `piece_o` in cycle n+1 if the FIFO was empty.
- Earliest valid piece is the first cycle after reset deasserts, plus any reject cycles.
- Pop: with `piece_yumi_i` high in cycle n, the next entry is on `piece_o` in cycle n+1. If no entry remains, `piece_v_o` is low in cycle n+1, unless a simultaneous push into the empty slot occurred.
- All outputs are registered; no combinational path from `random_i` or `piece_yumi_i` to any output.

## Test plan
- Reset, then `random_i` = 0,1,2 on consecutive cycles, no yumi:
  - `piece_v_o` rises in cycle 1;
  - `preview_o` holds 0,1,2 and `count_o` = 3 after cycle 3;
  - `bag_o` = 7'b1111000;
  - block stays in HOLD with no further bag change for 10 cycles.
- Rejection: bag 7'h7F, `random_i`[2:0] = 7 for 3 cycles then 4 → piece 4 accepted on the 4th cycle, `bag_o` = 7'b1101111.
- Fallback: after piece 0 is drawn, hold `random_i` = 0 → exactly 8 rejected cycles, then piece 1 (lowest remaining) is pushed; the reject counter returns to 0.
- Bag wrap: hold `piece_yumi_i` high and drive `random_i`[2:0] = 6,5,4,3,2,1,0,6 → first seven pops are a permutation of 0..6. `bag_o` shows 7'h7F after the 7th draw and 7'b0111111 after the 8th.
- Full with simultaneous pop/push, `queue_depth_p` = 3, FIFO = 2,5,1: yumi high with candidate 3 → `piece_o` = 5 next cycle, `preview_o` = 5,1,3, `count_o` stays 3.
- Reset mid-stream: assert `reset_n_i` low for one edge with `count_o` = 2 and `bag_o` = 7'b0010011 → next cycle `count_o` = 0, `piece_v_o` = 0, `bag_o` = 7'h7F, `preview_o` = 0.
